// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter
// Shares one SRAM-like port between instruction fetch (master 0) and the data
// path (master 1). One address phase is granted per cycle. The owner of every
// accepted request is remembered in an in-order ID FIFO so each in-order
// response can be steered back to the master that issued it.
module cpu_sram_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction master
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared slave port
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  // status
  output logic        busy,
  output logic        resp_err
);

  localparam int               CNT_W    = $clog2(OUTSTANDING + 1);
  localparam int               PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  // Master IDs as stored in the FIFO and used for the grant select.
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // ID FIFO storage and bookkeeping
  logic [OUTSTANDING-1:0] r_id_fifo;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  // A stalled address phase pins the port to its master until accepted, so
  // the slave never sees a request change underneath it.
  logic                   r_lock;
  logic                   r_lock_id;
  logic                   r_resp_err;

  logic                   w_sel;
  logic                   w_sel_req;
  logic                   w_not_full;
  logic                   w_not_empty;
  logic                   w_issue;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_orphan;
  logic                   w_head;

  // Pointers wrap at OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant select, issue qualification and response decode
  always_comb begin
    if (r_lock) begin
      w_sel = r_lock_id;
    end else if (data_req) begin
      w_sel = ID_DATA;
    end else begin
      w_sel = ID_INST;
    end
    w_sel_req   = (w_sel == ID_DATA) ? data_req : inst_req;
    // A full FIFO blocks issue even if a response frees a slot this cycle;
    // this keeps s_data_ok off the s_req timing path.
    w_not_full  = (r_count < CNT_MAX);
    w_not_empty = (r_count != '0);
    w_issue     = w_sel_req && w_not_full;
    w_accept    = w_issue && s_addr_ok;
    w_head      = r_id_fifo[r_rd_ptr];
    w_pop       = s_data_ok && w_not_empty;
    w_orphan    = s_data_ok && !w_not_empty;
  end

  // Slave payload mux; instruction fetches are always word reads
  always_comb begin
    s_req   = w_issue;
    s_wr    = 1'b0;
    s_size  = 2'd2;
    s_addr  = inst_addr;
    s_wstrb = 4'b0000;
    s_wdata = 32'h0000_0000;
    if (w_sel == ID_DATA) begin
      s_wr    = data_wr;
      s_size  = data_size;
      s_addr  = data_addr;
      s_wstrb = data_wstrb;
      s_wdata = data_wdata;
    end
  end

  // Handshake fan-out back to the masters
  always_comb begin
    inst_addr_ok = w_accept && (w_sel == ID_INST);
    data_addr_ok = w_accept && (w_sel == ID_DATA);
    inst_data_ok = w_pop && (w_head == ID_INST);
    data_data_ok = w_pop && (w_head == ID_DATA);
    inst_rdata   = s_rdata;
    data_rdata   = s_rdata;
    busy         = w_not_empty;
    resp_err     = r_resp_err;
  end

  // ID FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ID FIFO storage; entries are only read while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_id_fifo[r_wr_ptr] <= w_sel;
    end
  end

  // Port lock across a stalled address phase, plus sticky orphan-response flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lock     <= 1'b0;
      r_lock_id  <= ID_INST;
      r_resp_err <= 1'b0;
    end else begin
      if (w_issue) begin
        if (s_addr_ok) begin
          r_lock    <= 1'b0;
        end else begin
          r_lock    <= 1'b1;
          r_lock_id <= w_sel;
        end
      end
      if (w_orphan) begin
        r_resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_cpu_sram_arbiter;

  localparam int OUTSTANDING = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata;
  logic        s_addr_ok = 1'b0;
  logic        s_data_ok = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        busy, resp_err;

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .busy(busy), .resp_err(resp_err)
  );

  int checks = 0;
  int failures = 0;

  // Model state: owners of outstanding requests in issue order, the master
  // holding the port after a stall (-1 = none), the sticky error flag.
  int q[$];
  int held = -1;
  bit err = 1'b0;
  bit mvalid = 1'b0;

  // Model decisions for the current cycle, committed at the clock edge.
  int c_sel, c_head;
  bit c_sreq, c_acc, c_pop, c_spur;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Let inputs settle mid-cycle, evaluate the model and compare every output.
  task automatic settle();
    logic [70:0] exp_pl;
    #2;
    c_sel  = (held >= 0) ? held : (data_req ? 1 : 0);
    c_sreq = ((c_sel == 1) ? data_req : inst_req) && (q.size() < OUTSTANDING);
    c_acc  = c_sreq && s_addr_ok;
    c_pop  = s_data_ok && (q.size() > 0);
    c_spur = s_data_ok && (q.size() == 0);
    c_head = (q.size() > 0) ? q[0] : 0;
    if (mvalid) begin
      chk("s_req", s_req, c_sreq);
      chk("addr_ok", {inst_addr_ok, data_addr_ok}, {c_acc && c_sel == 0, c_acc && c_sel == 1});
      chk("data_ok", {inst_data_ok, data_data_ok}, {c_pop && c_head == 0, c_pop && c_head == 1});
      chk("busy_err", {busy, resp_err}, {q.size() > 0, err});
      chk("rdata", {inst_rdata, data_rdata}, {s_rdata, s_rdata});
      if (c_sreq) begin
        exp_pl = (c_sel == 1) ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                              : {1'b0, 2'd2, inst_addr, 4'h0, 32'h0};
        chk("payload", {s_wr, s_size, s_addr, s_wstrb, s_wdata}, exp_pl);
      end
    end
  endtask

  // Clock edge: commit the model, then step just past the edge.
  task automatic advance();
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      held   = -1;
      err    = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (c_pop) void'(q.pop_front());
      if (c_acc) q.push_back(c_sel);
      if (c_sreq) held = s_addr_ok ? -1 : c_sel;
      if (c_spur) err = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    inst_req  = 1'b0;
    data_req  = 1'b0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    settle(); advance();
    settle(); advance();
    resetn = 1'b1;
  endtask

  initial begin
    bit drop_i, drop_d;

    // Reset state
    do_reset();
    settle();
    chk("rst_out", {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, resp_err}, 7'b0);
    advance();

    // Single instruction fetch and its response
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; s_addr_ok = 1'b1;
    settle();
    chk("t1_issue", {s_req, inst_addr_ok, data_addr_ok, s_wr, s_size, s_addr},
        {1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'hBFC0_0000});
    advance();
    inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h3C1D_0001;
    settle();
    chk("t1_resp", {inst_data_ok, data_data_ok, busy, inst_rdata}, {1'b1, 1'b0, 1'b1, 32'h3C1D_0001});
    advance();
    s_data_ok = 1'b0;
    settle();
    chk("t1_idle", busy, 1'b0);
    advance();

    // Simultaneous requests: data wins, inst follows, responses route in order
    inst_req = 1'b1; inst_addr = 32'h0040_0000;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_1000;
    data_wstrb = 4'hF; data_wdata = 32'h1234_5678; s_addr_ok = 1'b1;
    settle();
    chk("t2_grant0", {data_addr_ok, inst_addr_ok, s_wr, s_addr, s_wstrb, s_wdata},
        {1'b1, 1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678});
    advance();
    data_req = 1'b0;
    settle();
    chk("t2_grant1", {inst_addr_ok, data_addr_ok, s_addr, busy}, {1'b1, 1'b0, 32'h0040_0000, 1'b1});
    advance();
    inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hAAAA_5555;
    settle();
    chk("t2_resp0", {data_data_ok, inst_data_ok, data_rdata}, {1'b1, 1'b0, 32'hAAAA_5555});
    advance();
    s_rdata = 32'h0BAD_0BAD;
    settle();
    chk("t2_resp1", {inst_data_ok, data_data_ok, inst_rdata}, {1'b1, 1'b0, 32'h0BAD_0BAD});
    advance();
    s_data_ok = 1'b0;

    // Stalled inst request keeps the port when data arrives
    inst_req = 1'b1; inst_addr = 32'h0040_0010; s_addr_ok = 1'b0;
    repeat (3) begin settle(); advance(); end
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h0000_2002;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    settle();
    chk("t3_lock", {s_req, data_addr_ok, inst_addr_ok, s_addr}, {1'b1, 1'b0, 1'b0, 32'h0040_0010});
    advance();
    s_addr_ok = 1'b1;
    settle();
    chk("t3_release", {inst_addr_ok, data_addr_ok}, 2'b10);
    advance();
    inst_req = 1'b0;
    settle();
    chk("t3_data", {data_addr_ok, s_addr, s_size}, {1'b1, 32'h0000_2002, 2'd1});
    advance();
    data_req = 1'b0;

    // FIFO full (inst, data outstanding): third request waits, even through a pop
    inst_req = 1'b1; inst_addr = 32'h0040_0020; s_addr_ok = 1'b1;
    settle();
    chk("t4_full", {s_req, inst_addr_ok, busy}, 3'b001);
    advance();
    s_data_ok = 1'b1;
    settle();
    chk("t4_full_pop", {s_req, inst_data_ok}, 2'b01);
    advance();
    s_data_ok = 1'b0;
    settle();
    chk("t4_issue", {s_req, inst_addr_ok}, 2'b11);
    advance();
    inst_req = 1'b0; s_addr_ok = 1'b0;

    // Reset with two outstanding discards them
    resetn = 1'b0;
    settle(); advance();
    resetn = 1'b1;
    settle();
    chk("t6_rst", {busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, s_req}, 6'b0);
    advance();

    // Reset also releases a port lock
    inst_req = 1'b1; inst_addr = 32'h0040_0030; s_addr_ok = 1'b0;
    settle(); advance();
    resetn = 1'b0;
    settle(); advance();
    resetn = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_3000;
    settle();
    chk("t6_unlock", {s_req, s_addr}, {1'b1, 32'h0000_3000});
    advance();

    // Orphan response raises a sticky error cleared only by reset
    do_reset();
    s_data_ok = 1'b1;
    settle();
    chk("t5_orphan", {inst_data_ok, data_data_ok, busy}, 3'b000);
    advance();
    s_data_ok = 1'b0;
    settle();
    chk("t5_err", resp_err, 1'b1);
    advance();
    repeat (3) begin settle(); advance(); end
    settle();
    chk("t5_hold", resp_err, 1'b1);
    advance();
    resetn = 1'b0;
    settle(); advance();
    resetn = 1'b1;
    settle();
    chk("t5_clear", resp_err, 1'b0);
    advance();

    // Randomized traffic; masters hold payload until accepted
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req  = 1'b1;
        inst_addr = $urandom;
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req   = 1'b1;
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      s_addr_ok = ($urandom_range(0, 9) < 6);
      s_data_ok = ((q.size() > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 99) == 0);
      s_rdata   = $urandom;
      resetn    = ($urandom_range(0, 299) != 0);
      settle();
      drop_i = !resetn || (c_acc && c_sel == 0);
      drop_d = !resetn || (c_acc && c_sel == 1);
      advance();
      if (drop_i) inst_req = 1'b0;
      if (drop_d) data_req = 1'b0;
    end
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
